// File: rtl/elastic_pipe_reg_pkg.sv
// pipe_pkg: shared types and sizing helpers for the elastic pipeline register.
package pipe_pkg;
    localparam int MIN_DEPTH = 1;
    typedef logic adv_bit_t;
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction
endpackage

// File: rtl/elastic_pipe_reg_if.sv
// elastic_pipe_reg_if: valid/ready bus with enable, flush and occupancy.
interface elastic_pipe_reg_if
    import pipe_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
);
    logic en;
    logic flush;
    logic in_valid;
    logic in_ready;
    logic [WIDTH-1:0] in_data;
    logic out_valid;
    logic out_ready;
    logic [WIDTH-1:0] out_data;
    logic [cnt_width(DEPTH)-1:0] count;
    modport master (
        output en, flush, in_valid, in_data, out_ready,
        input in_ready, out_valid, out_data, count
    );
    modport slave (
        input en, flush, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, count
    );
endinterface

// File: rtl/elastic_pipe_stage.sv
// elastic_pipe_stage: one valid/data slot; flush clears valid even when not loading.
module elastic_pipe_stage #(
    parameter int WIDTH = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic flush,
    input  logic src_valid,
    input  logic [WIDTH-1:0] src_data,
    output logic v,
    output logic v_nxt,
    output logic [WIDTH-1:0] d
);
    assign v_nxt = flush ? 1'b0 : load ? src_valid : v;
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            v <= 1'b0;
            d <= RESET_VAL;
        end else begin
            v <= v_nxt;
            if (load && src_valid) d <= src_data;
        end
endmodule

// File: rtl/elastic_pipe_reg.sv
// elastic_pipe_reg: DEPTH-stage valid/ready pipeline with bubble collapse,
// global enable and synchronous flush.
module elastic_pipe_reg
    import pipe_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input logic clk,
    input logic reset,
    elastic_pipe_reg_if.slave bus
);
    localparam int D = (DEPTH < MIN_DEPTH) ? MIN_DEPTH : DEPTH;
    localparam int CW = cnt_width(D);
    adv_bit_t [D-1:0] adv;
    adv_bit_t [D-1:0] load;
    adv_bit_t [D-1:0] v;
    adv_bit_t [D-1:0] v_nxt;
    logic [WIDTH-1:0] d [D];
    logic [CW-1:0] count_q;
    for (genvar i = 0; i < D; i++) begin : g_stage
        logic src_valid;
        logic [WIDTH-1:0] src_data;
        if (i == D - 1) begin : g_last
            assign adv[i] = bus.en & bus.out_ready;
        end else begin : g_mid
            assign adv[i] = bus.en & (~v[i+1] | adv[i+1]);
        end
        if (i == 0) begin : g_first
            assign src_valid = bus.in_valid;
            assign src_data  = bus.in_data;
        end else begin : g_next
            assign src_valid = v[i-1];
            assign src_data  = d[i-1];
        end
        // an empty slot always loads, which is what squeezes out bubbles
        assign load[i] = bus.en & (~v[i] | adv[i]);
        elastic_pipe_stage #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_stage (
            .clk(clk),
            .reset(reset),
            .load(load[i]),
            .flush(bus.flush),
            .src_valid(src_valid),
            .src_data(src_data),
            .v(v[i]),
            .v_nxt(v_nxt[i]),
            .d(d[i])
        );
    end
    always_ff @(posedge clk or posedge reset)
        if (reset) count_q <= '0;
        else count_q <= CW'($countones(v_nxt));
    assign bus.in_ready  = load[0] & ~bus.flush & ~reset;
    assign bus.out_valid = v[D-1] & bus.en;
    assign bus.out_data  = d[D-1];
    assign bus.count     = count_q;
endmodule

// File: tb/tb_elastic_pipe_reg.sv
// tb_elastic_pipe_reg: directed scenarios checked against a FIFO scoreboard of accepted items.
module tb_elastic_pipe_reg;
    import pipe_pkg::*;
    localparam int W = 32;
    localparam int D = 3;
    localparam logic [W-1:0] RV = 32'hDEAD_BEEF;
    logic clk = 1'b0;
    logic reset = 1'b1;
    elastic_pipe_reg_if #(.WIDTH(W), .DEPTH(D)) bus ();
    elastic_pipe_reg #(.WIDTH(W), .DEPTH(D), .RESET_VAL(RV)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );
    always #5 clk = ~clk;
    logic [W-1:0] q[$];
    int qc[$];
    int vectors = 0;
    int errors = 0;
    int cyc = 0;
    int acc = 0;
    int dlv = 0;
    int maxc = 0;
    int base;
    bit lat_chk = 0;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask
    // sample at negedge: score handshakes, then advance one edge
    task automatic step();
        logic [W-1:0] e;
        int lc;
        @(negedge clk);
        chk("count", 32'(bus.count), 32'(q.size()));
        if (int'(bus.count) > maxc) maxc = int'(bus.count);
        if (bus.out_valid && bus.out_ready) begin
            e = q.size() != 0 ? q.pop_front() : 'x;
            lc = qc.size() != 0 ? qc.pop_front() : -100;
            chk("out_data", bus.out_data, e);
            if (lat_chk) chk("latency", 32'(cyc - lc), 32'(D));
            dlv++;
        end
        if (bus.in_valid && bus.in_ready) begin
            q.push_back(bus.in_data);
            qc.push_back(cyc);
            acc++;
        end
        if (bus.flush) begin
            q.delete();
            qc.delete();
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    initial begin
        bus.en = 1'b1;
        bus.flush = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_out_data", bus.out_data, RV);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_count", 32'(bus.count), 32'd0);
        chk("rst_in_ready_idle", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;
        // streaming
        bus.out_ready = 1'b1;
        lat_chk = 1;
        for (int i = 1; i <= 4; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data = W'(i);
            step();
        end
        bus.in_valid = 1'b0;
        repeat (5) step();
        lat_chk = 0;
        chk("stream_acc", 32'(acc), 32'd4);
        chk("stream_dlv", 32'(dlv), 32'd4);
        chk("stream_maxc", 32'(maxc), 32'd3);
        // backpressure
        acc = 0;
        dlv = 0;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data = W'(acc + 1);
            step();
        end
        chk("bp_acc", 32'(acc), 32'd3);
        chk("bp_full_ready", 32'(bus.in_ready), 32'd0);
        bus.out_ready = 1'b1;
        #1;
        chk("bp_full_pass_ready", 32'(bus.in_ready), 32'd1);
        for (int t = 0; t < 20 && acc < 5; t++) begin
            bus.in_data = W'(acc + 1);
            step();
        end
        bus.in_valid = 1'b0;
        chk("bp_acc_all", 32'(acc), 32'd5);
        repeat (5) step();
        chk("bp_dlv", 32'(dlv), 32'd5);
        // bubble collapse
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data = 32'hA;
        step();
        bus.in_valid = 1'b0;
        step();
        bus.in_valid = 1'b1;
        bus.in_data = 32'hB;
        step();
        bus.in_valid = 1'b0;
        step();
        chk("bub_count", 32'(bus.count), 32'd2);
        bus.out_ready = 1'b1;
        base = dlv;
        step();
        step();
        chk("bub_dlv", 32'(dlv - base), 32'd2);
        // flush
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data = W'(32'h11 + i);
            step();
        end
        bus.in_data = 32'h9;
        bus.flush = 1'b1;
        #1;
        chk("flush_in_ready", 32'(bus.in_ready), 32'd0);
        step();
        bus.flush = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        chk("flush_count", 32'(bus.count), 32'd0);
        chk("flush_out_valid", 32'(bus.out_valid), 32'd0);
        bus.out_ready = 1'b1;
        base = dlv;
        repeat (4) step();
        chk("flush_dlv", 32'(dlv - base), 32'd0);
        // enable low freezes the pipe
        bus.out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data = W'(32'h21 + i);
            step();
        end
        bus.in_valid = 1'b0;
        step();
        bus.en = 1'b0;
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data = 32'h99;
        base = dlv;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("en0_out_valid", 32'(bus.out_valid), 32'd0);
            chk("en0_in_ready", 32'(bus.in_ready), 32'd0);
            chk("en0_count", 32'(bus.count), 32'd2);
        end
        bus.in_valid = 1'b0;
        bus.en = 1'b1;
        repeat (4) step();
        chk("en0_dlv", 32'(dlv - base), 32'd2);
        // flush while disabled still clears valids
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data = 32'h31;
        step();
        bus.in_valid = 1'b0;
        bus.en = 1'b0;
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        bus.en = 1'b1;
        #1;
        chk("flush_en0_count", 32'(bus.count), 32'd0);
        chk("flush_en0_out_valid", 32'(bus.out_valid), 32'd0);
        // reset mid-operation
        for (int i = 0; i < 2; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data = W'(32'h41 + i);
            step();
        end
        bus.in_valid = 1'b0;
        reset = 1'b1;
        q.delete();
        qc.delete();
        #1;
        chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_rst_count", 32'(bus.count), 32'd0);
        chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("mid_rst_out_data", bus.out_data, RV);
        @(posedge clk);
        #1;
        reset = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data = 32'h43;
        bus.out_ready = 1'b1;
        base = dlv;
        step();
        bus.in_valid = 1'b0;
        repeat (4) step();
        chk("mid_rst_dlv", 32'(dlv - base), 32'd1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/elastic_pipe_reg.md
Name: elastic_pipe_reg

Overview:
- Parametrised multi-stage pipeline register with per-stage valid bits, valid/ready backpressure, global enable and synchronous flush.
- Successor to the single enabled flip-flop. Used between datapath stages of the pipelined processor so stalls and branch flushes are handled in one block instead of ad-hoc enables.
- Throughput is one item per cycle. Bubbles are squeezed out under backpressure.

Parameters:
- WIDTH, 32, data bits per stage.
- DEPTH, 2, number of register stages (legal range DEPTH >= 1).
- RESET_VAL, '0, value loaded into every data register on reset.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- en  in  1  global enable. 0 freezes the whole pipe.
- flush  in  1  synchronous kill of all in-flight items.
- in_valid  in  1  upstream item valid.
- in_data  in  WIDTH  upstream data.
- in_ready  out  1  pipe accepts the item this cycle.
- out_valid  out  1  last-stage item valid.
- out_data  out  WIDTH  last-stage data.
- out_ready  in  1  downstream accepts.
- count  out  $clog2(DEPTH+1)  number of valid stages.

Behaviour:
- Reset (async, active-high, clock = clk): all stage valid bits = 0; all stage data = RESET_VAL; out_valid=0; out_data=RESET_VAL; count=0.
- in_ready is 0 while reset is asserted.
- State per stage i (0 = input side, DEPTH-1 = output side): v[i], d[i].
- Advance terms (combinational):
  - adv[DEPTH-1] = en & out_ready.
  - adv[i] = en & (!v[i+1] | adv[i+1]) for i < DEPTH-1.
  - Each stage loads when its own slot is free or being vacated: load[i] = en & (!v[i] | adv[i]).
  - in_ready = load[0] & !flush.
- Stage 0 on a load: v[0] <= in_valid & !flush; d[0] <= in_data when in_valid, otherwise d[0] holds.
- Stage i>0 on a load: v[i] <= v[i-1] & !flush; d[i] <= d[i-1] when v[i-1].
- Bubbles: a stage with v=0 is overwritten regardless of downstream ready, so bubbles collapse.
- Outputs:
  - out_valid = v[DEPTH-1] & en.
  - out_data = d[DEPTH-1], always driven, meaningful only when out_valid.
  - Output transfer happens when out_valid & out_ready.
  - Input transfer happens when in_valid & in_ready.
- Latency: an item accepted at edge N appears on out_valid after edge N+DEPTH-1 (visible in cycle N+DEPTH-1 → N+DEPTH). This holds when there is no backpressure.
- en=0:
  - No register changes; in_ready=0; out_valid=0.
  - count still reports the stored occupancy.
  - Data is preserved across any length of disable.
- flush=1 (synchronous, takes effect when en=1):
  - At the next edge all v[i] <= 0; data registers are not cleared.
  - in_ready=0 during the flush cycle, so no input is accepted.
  - The output handshake completing in the flush cycle still counts as delivered.
- flush with en=0: v[i] still cleared. Flush overrides en for the valid bits only.
- count: registered popcount of v, updated on the same edge as v. Range 0..DEPTH.
- Full: count==DEPTH and !out_ready → in_ready=0.
- Full with out_ready=1: in_ready=1, giving simultaneous accept+emit; count is unchanged.
- Reset mid-operation: all in-flight items are lost and there is no partial output. Next accept is allowed on the first edge after reset deasserts.

Decomposition:
- Package pipe_pkg:
  - function cnt_width(depth) returning $clog2(depth+1).
  - typedef of the advance-vector type.
  - localparam MIN_DEPTH=1.
- Sub-module elastic_pipe_stage: one v/d pair, with load, flush, reset and RESET_VAL pass-through.
- Top level generates DEPTH instances, the advance chain, and the count register.

Test Plan:
- Reset then idle (WIDTH=32, DEPTH=3, RESET_VAL=32'hDEAD_BEEF) → out_data=32'hDEADBEEF, out_valid=0, count=0, in_ready=1.
- Streaming: push 0x1,0x2,0x3,0x4 back-to-back with out_ready=1 → 0x1 seen after 2 edges, one item per cycle thereafter, in order, count peaks at 3.
- Backpressure: out_ready=0, push 5 items → exactly 3 accepted (in_ready drops when count=3). Then out_ready=1 → 0x1,0x2,0x3 drained, then 0x4,0x5 accepted and delivered.
- Bubble collapse: push A, idle 1 cycle, push B, with out_ready=0 → B lands directly behind A, count=2, no gap seen at output on release.
- Flush: 3 items in flight, assert flush 1 cycle while in_valid=1 with 0x9 → next cycle count=0, out_valid=0. 0x9 is not accepted and never appears.
- en=0 for 4 cycles with 2 items held and out_ready=1 → no output, in_ready=0, count stays 2. Items emerge in order after en=1.
